// File: rtl/io_int_pkg.sv
// Shared constants and helpers for the GPIO interrupt controller.
package io_int_pkg;

  localparam int N_CH_DEF  = 13;
  localparam int SYNC_DEF  = 2;
  localparam int DEB_W_DEF = 16;

  localparam int SW0  = 0;
  localparam int SW1  = 1;
  localparam int SW2  = 2;
  localparam int SW3  = 3;
  localparam int SW4  = 4;
  localparam int SW5  = 5;
  localparam int SW6  = 6;
  localparam int SW7  = 7;
  localparam int BTN0 = 8;
  localparam int BTN1 = 9;
  localparam int BTN2 = 10;
  localparam int BTN3 = 11;
  localparam int BTN4 = 12;

  // A single-channel build still needs a 1-bit pending-ID port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One channel: pin synchroniser followed by a counter-based debounce filter.
module io_debounce
  import io_int_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_DEF,
  parameter int DEB_W       = DEB_W_DEF
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             in_raw,
  input  logic [DEB_W-1:0] deb_limit,
  output logic             filt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DEB_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   sync;
  logic [DEB_W:0]         cnt_inc;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_raw};
    sync    = sync_q[SYNC_STAGES-1];
    cnt_inc = {1'b0, cnt_q} + (DEB_W+1)'(1);
    cnt_d   = '0;
    filt_d  = filt_q;
    // The extra bit keeps the limit compare exact even at cnt = all ones.
    if (sync != filt_q) begin
      if (cnt_inc >= {1'b0, deb_limit}) filt_d = sync;
      else                              cnt_d  = cnt_inc[DEB_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;

endmodule

// File: rtl/io_int_ctrl.sv
// GPIO interrupt controller: debounced inputs, edge/level detection,
// sticky status, lowest-index pending ID and a registered interrupt line.
module io_int_ctrl
  import io_int_pkg::*;
#(
  parameter  int N_CH        = N_CH_DEF,
  parameter  int SYNC_STAGES = SYNC_DEF,
  parameter  int DEB_W       = DEB_W_DEF,
  localparam int ID_W        = id_width(N_CH)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [N_CH-1:0]  in_raw,
  input  logic [DEB_W-1:0] deb_limit,
  input  logic [N_CH-1:0]  int_ena,
  input  logic [N_CH-1:0]  int_clr,
  input  logic [N_CH-1:0]  int_pos,
  input  logic [N_CH-1:0]  int_neg,
  input  logic [N_CH-1:0]  int_level,
  input  logic             invoke_int,
  output logic [N_CH-1:0]  in_filt,
  output logic [N_CH-1:0]  int_sts,
  output logic             pend_vld,
  output logic [ID_W-1:0]  pend_id,
  output logic             interrupt
);

  logic [N_CH-1:0] filt;
  logic [N_CH-1:0] prev_q, prev_d;
  logic [N_CH-1:0] sts_q, sts_d;
  logic [N_CH-1:0] rise, fall, set_edge, set_lvl, set_v;
  logic            irq_q, irq_d;
  logic            pend_vld_q, pend_vld_d;
  logic [ID_W-1:0] pend_id_q, pend_id_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    io_debounce #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEB_W      (DEB_W)
    ) u_deb (
      .clk      (clk),
      .res_n    (res_n),
      .in_raw   (in_raw[g]),
      .deb_limit(deb_limit),
      .filt     (filt[g])
    );
  end

  always_comb begin
    prev_d   = filt;
    rise     = filt & ~prev_q;
    fall     = ~filt & prev_q;
    set_edge = (rise & int_pos) | (fall & int_neg);
    set_lvl  = (filt & int_pos) | (~filt & int_neg);
    set_v    = (int_level & set_lvl) | (~int_level & set_edge) | {N_CH{invoke_int}};
    // Disable dominates, then set, then clear; a live level re-sets over a clear.
    sts_d    = int_ena & (set_v | (sts_q & ~int_clr));
  end

  always_comb begin
    irq_d      = |sts_q;
    pend_vld_d = |sts_q;
    pend_id_d  = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (sts_q[i]) pend_id_d = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      prev_q     <= '0;
      sts_q      <= '0;
      irq_q      <= 1'b0;
      pend_vld_q <= 1'b0;
      pend_id_q  <= '0;
    end else begin
      prev_q     <= prev_d;
      sts_q      <= sts_d;
      irq_q      <= irq_d;
      pend_vld_q <= pend_vld_d;
      pend_id_q  <= pend_id_d;
    end
  end

  assign in_filt   = filt;
  assign int_sts   = sts_q;
  assign pend_vld  = pend_vld_q;
  assign pend_id   = pend_id_q;
  assign interrupt = irq_q;

endmodule

// File: tb/tb_io_int_ctrl.sv
// Scoreboard bench for io_int_ctrl: a cycle-level reference model pushes the
// expected outputs after every clock edge and a monitor pops and compares them.
module tb_io_int_ctrl;

  localparam int N     = 13;
  localparam int SYNC  = 2;
  localparam int DW    = 16;
  localparam int IW    = 4;

  typedef struct packed {
    logic [N-1:0]  filt;
    logic [N-1:0]  sts;
    logic          irq;
    logic          vld;
    logic [IW-1:0] id;
  } exp_t;

  logic          clk;
  logic          res_n;
  logic [N-1:0]  in_raw;
  logic [DW-1:0] deb_limit;
  logic [N-1:0]  int_ena, int_clr, int_pos, int_neg, int_level;
  logic          invoke_int;
  logic [N-1:0]  in_filt, int_sts;
  logic          pend_vld, interrupt;
  logic [IW-1:0] pend_id;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];

  io_int_ctrl #(.N_CH(N), .SYNC_STAGES(SYNC), .DEB_W(DW)) dut (
    .clk       (clk),
    .res_n     (res_n),
    .in_raw    (in_raw),
    .deb_limit (deb_limit),
    .int_ena   (int_ena),
    .int_clr   (int_clr),
    .int_pos   (int_pos),
    .int_neg   (int_neg),
    .int_level (int_level),
    .invoke_int(invoke_int),
    .in_filt   (in_filt),
    .int_sts   (int_sts),
    .pend_vld  (pend_vld),
    .pend_id   (pend_id),
    .interrupt (interrupt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int lowest_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  // Reference model: per-channel run lengths and plain vectors, stepped once per edge.
  logic [N-1:0] m_filt, m_prev, m_sts, m_sync_v, m_set;
  logic [N-1:0] m_syncq[$];
  int           m_run[N];
  logic         m_irq, m_vld;
  int           m_id;

  always @(posedge clk) begin
    if (!res_n) begin
      m_filt = '0; m_prev = '0; m_sts = '0;
      m_irq = 1'b0; m_vld = 1'b0; m_id = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_syncq = {};
      for (int s = 0; s < SYNC; s++) m_syncq.push_back('0);
    end else begin
      m_irq = (m_sts != '0);
      m_vld = m_irq;
      m_id  = lowest_set(m_sts);
      for (int i = 0; i < N; i++) begin
        if (int_level[i])
          m_set[i] = m_filt[i] ? int_pos[i] : int_neg[i];
        else
          m_set[i] = (m_filt[i] && !m_prev[i] && int_pos[i]) ||
                     (!m_filt[i] && m_prev[i] && int_neg[i]);
        if (invoke_int) m_set[i] = 1'b1;
        if (!int_ena[i])     m_sts[i] = 1'b0;
        else if (m_set[i])   m_sts[i] = 1'b1;
        else if (int_clr[i]) m_sts[i] = 1'b0;
      end
      m_prev   = m_filt;
      m_sync_v = m_syncq.pop_front();
      m_syncq.push_back(in_raw);
      for (int i = 0; i < N; i++) begin
        if (m_sync_v[i] == m_filt[i]) m_run[i] = 0;
        else if (m_run[i] + 1 >= int'(deb_limit)) begin
          m_filt[i] = m_sync_v[i];
          m_run[i]  = 0;
        end else m_run[i] = m_run[i] + 1;
      end
    end
    exp_q.push_back('{filt: m_filt, sts: m_sts, irq: m_irq, vld: m_vld, id: IW'(m_id)});
  end

  // Monitor: outputs are presented every cycle.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_empty actual=0 expected=1 at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      cmp("sb_filt", 32'(in_filt), 32'(e.filt));
      cmp("sb_sts",  32'(int_sts), 32'(e.sts));
      cmp("sb_irq",  32'(interrupt), 32'(e.irq));
      cmp("sb_vld",  32'(pend_vld), 32'(e.vld));
      cmp("sb_id",   32'(pend_id), 32'(e.id));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic check_all_zero(input string tag);
    cmp({tag, "_filt"}, 32'(in_filt), 32'h0);
    cmp({tag, "_sts"},  32'(int_sts), 32'h0);
    cmp({tag, "_irq"},  32'(interrupt), 32'h0);
    cmp({tag, "_vld"},  32'(pend_vld), 32'h0);
    cmp({tag, "_id"},   32'(pend_id), 32'h0);
  endtask

  initial begin
    res_n = 1'b0; in_raw = '0; deb_limit = '0; int_ena = '0; int_clr = '0;
    int_pos = '0; int_neg = '0; int_level = '0; invoke_int = 1'b0;
    step(3);
    check_all_zero("reset");
    res_n = 1'b1;
    step(1);
    check_all_zero("post_release");

    // Debounced rising edge on channel 0 with deb_limit 4.
    deb_limit = 16'd4; int_ena = 13'h001; int_pos = 13'h001;
    step(2);
    in_raw[0] = 1'b1;
    step(5);
    cmp("lat_filt_early", 32'(in_filt[0]), 32'h0);
    step(1);
    cmp("lat_filt", 32'(in_filt[0]), 32'h1);
    cmp("lat_sts_early", 32'(int_sts[0]), 32'h0);
    step(1);
    cmp("lat_sts", 32'(int_sts[0]), 32'h1);
    cmp("lat_irq_early", 32'(interrupt), 32'h0);
    step(1);
    cmp("lat_irq", 32'(interrupt), 32'h1);
    cmp("lat_id", 32'(pend_id), 32'h0);
    int_clr[0] = 1'b1;
    step(1);
    int_clr[0] = 1'b0;
    in_raw[0] = 1'b0;
    step(10);

    // 3-cycle glitch is shorter than the debounce length.
    in_raw[0] = 1'b1;
    step(3);
    in_raw[0] = 1'b0;
    step(10);
    cmp("glitch_filt", 32'(in_filt[0]), 32'h0);
    cmp("glitch_sts", 32'(int_sts[0]), 32'h0);
    cmp("glitch_irq", 32'(interrupt), 32'h0);

    // Two channels fire together; priority goes to the lower index.
    int_ena = 13'h208; int_pos = 13'h208;
    in_raw[3] = 1'b1; in_raw[9] = 1'b1;
    step(12);
    cmp("prio_id3", 32'(pend_id), 32'd3);
    cmp("prio_vld", 32'(pend_vld), 32'h1);
    int_clr[3] = 1'b1;
    step(1);
    int_clr[3] = 1'b0;
    step(1);
    cmp("prio_id9", 32'(pend_id), 32'd9);
    int_clr[9] = 1'b1;
    step(1);
    int_clr[9] = 1'b0;
    step(1);
    cmp("prio_vld_off", 32'(pend_vld), 32'h0);
    cmp("prio_irq_off", 32'(interrupt), 32'h0);

    // Active-low level on channel 5 survives clears until the level goes away.
    int_ena[5] = 1'b1; int_level[5] = 1'b1; int_neg[5] = 1'b1;
    step(2);
    for (int r = 0; r < 4; r++) begin
      int_clr[5] = 1'b1;
      step(1);
      int_clr[5] = 1'b0;
      step(1);
      cmp("level_hold", 32'(int_sts[5]), 32'h1);
    end
    in_raw[5] = 1'b1;
    step(10);
    int_clr[5] = 1'b1;
    step(1);
    int_clr[5] = 1'b0;
    step(1);
    cmp("level_clr", 32'(int_sts[5]), 32'h0);

    // Forced set beats a simultaneous clear.
    int_ena = '0;
    step(1);
    int_ena = 13'h0A5; invoke_int = 1'b1; int_clr = '1;
    step(1);
    invoke_int = 1'b0; int_clr = '0;
    cmp("invoke_sts", 32'(int_sts), 32'h0A5);
    step(1);
    cmp("invoke_id", 32'(pend_id), 32'h0);
    cmp("invoke_vld", 32'(pend_vld), 32'h1);

    // Reset mid-interrupt and mid-debounce.
    int_level = '0; int_pos = '1; int_neg = '0; int_ena = '1; invoke_int = 1'b1;
    step(1);
    invoke_int = 1'b0;
    cmp("all_set", 32'(int_sts), 32'h1FFF);
    deb_limit = 16'd20; in_raw[1] = 1'b1;
    step(5);
    res_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    step(3);
    res_n = 1'b1;
    step(3);
    cmp("rst_quiet", 32'(int_sts), 32'h0);
    step(30);
    cmp("rst_reedge", 32'(int_sts), 32'h22A);
    cmp("rst_reedge_id", 32'(pend_id), 32'd1);

    // Randomised traffic against the model.
    deb_limit = 16'd2;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 11) == 0) in_raw[i] = ~in_raw[i];
      if ($urandom_range(0, 49) == 0) deb_limit = DW'($urandom_range(0, 6));
      if ($urandom_range(0, 39) == 0) begin
        int_ena   = N'($urandom);
        int_pos   = N'($urandom);
        int_neg   = N'($urandom);
        int_level = N'($urandom);
      end
      int_clr    = N'($urandom & $urandom & $urandom);
      invoke_int = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 399) == 0) begin
        res_n = 1'b0;
        #1;
        cmp("rand_async_rst", 32'(int_sts), 32'h0);
        step(2);
        res_n = 1'b1;
      end else begin
        step(1);
      end
    end
    invoke_int = 1'b0; int_clr = '0;
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
